crc32_byte_serializer: RTL

Upstream feeder for the serial CRC-32 generator (`CRC_32_serial`). It accepts a frame as bytes over a valid/ready handshake and converts it into the generator's serial control protocol:
- one-cycle `load` pulse;
- frame bits on `crc_in`, MSB-first, one per clock, with no gaps;
- one-cycle `d_finish` pulse;
- a 32-cycle drain window while the generator shifts out `crc_out`.

It double-buffers one byte so that multi-byte frames produce a gap-free bitstream. Input underruns abort the frame.

---
 rtl/crc32_pkg.sv | 22 ++
 rtl/crc32_byte_serializer_byte_holdbuf.sv | 44 ++++
 rtl/crc32_byte_serializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/crc32_pkg.sv
// Shared definitions for the serial CRC-32 path: serializer FSM states, drain
// length and the generator polynomial with a one-bit update step.
package crc32_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_FINISH,
        S_DRAIN,
        S_DISCARD
    } state_t;

    localparam int          CRC_W      = 32;
    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    // MSB-first single-bit CRC-32 update, same bit order the serializer emits.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic b);
        return {crc[30:0], 1'b0} ^ ((crc[31] ^ b) ? CRC32_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_byte_serializer_byte_holdbuf.sv
// One-entry byte hold register with valid/last flags; push/pop interface and a
// flush used when a frame is aborted.
module byte_holdbuf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);
    import crc32_pkg::*;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // Flush beats a same-cycle push: a byte arriving on the abort edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/crc32_byte_serializer.sv
// Byte-to-bit serializer feeding the serial CRC-32 generator: load pulse,
// gap-free MSB-first bitstream, d_finish pulse, then a CRC_W-cycle drain.
module crc32_byte_serializer #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = crc32_pkg::CRC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              load,
    output logic              crc_in,
    output logic              d_finish,
    output logic              busy,
    output logic              underrun
);
    import crc32_pkg::*;

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DCW = (CRC_W > 1) ? $clog2(CRC_W) : 1;

    state_t            r_state;
    logic [DATA_W-1:0] r_sr;
    logic              r_sr_last;
    logic [BCW-1:0]    r_bcnt;
    logic [DCW-1:0]    r_dcnt;
    logic              r_last_taken;
    logic              r_load;
    logic              r_crc_in;
    logic              r_d_finish;
    logic              r_underrun;

    logic              w_ready;
    logic              w_xfer;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_bit_last;
    logic              w_hold_valid;
    logic              w_hold_last;
    logic [DATA_W-1:0] w_hold_data;

    always_comb begin
        w_ready = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_IDLE, S_DISCARD: w_ready = 1'b1;
                S_LOAD, S_SHIFT:   w_ready = !w_hold_valid && !r_last_taken;
                default:           w_ready = 1'b0;
            endcase
        end
    end

    assign w_xfer     = s_valid && w_ready;
    assign w_bit_last = (r_bcnt == BCW'(DATA_W - 1));
    assign w_push     = w_xfer && (r_state != S_DISCARD);
    assign w_pop      = (r_state == S_LOAD) ||
                        ((r_state == S_SHIFT) && w_bit_last && !r_sr_last && w_hold_valid);
    assign w_flush    = (r_state == S_SHIFT) && w_bit_last && !r_sr_last && !w_hold_valid;

    byte_holdbuf #(
        .DATA_W(DATA_W)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_data (s_data),
        .i_last (s_last),
        .i_pop  (w_pop),
        .i_flush(w_flush),
        .o_valid(w_hold_valid),
        .o_data (w_hold_data),
        .o_last (w_hold_last)
    );

    // crc_in is registered from the bit that will sit at sr's MSB after the edge,
    // so the first bit appears the cycle right after load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_sr_last    <= 1'b0;
            r_bcnt       <= '0;
            r_dcnt       <= '0;
            r_last_taken <= 1'b0;
            r_load       <= 1'b0;
            r_crc_in     <= 1'b0;
            r_d_finish   <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_load     <= 1'b0;
            r_crc_in   <= 1'b0;
            r_d_finish <= 1'b0;
            r_underrun <= 1'b0;
            if (w_xfer && s_last && (r_state != S_DISCARD)) begin
                r_last_taken <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_state <= S_LOAD;
                        r_load  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_sr      <= w_hold_data;
                    r_sr_last <= w_hold_last;
                    r_bcnt    <= '0;
                    r_crc_in  <= w_hold_data[DATA_W-1];
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!w_bit_last) begin
                        r_sr     <= r_sr << 1;
                        r_bcnt   <= r_bcnt + 1'b1;
                        r_crc_in <= r_sr[DATA_W-2];
                    end else if (r_sr_last) begin
                        r_state    <= S_FINISH;
                        r_d_finish <= 1'b1;
                    end else if (w_hold_valid) begin
                        r_sr      <= w_hold_data;
                        r_sr_last <= w_hold_last;
                        r_bcnt    <= '0;
                        r_crc_in  <= w_hold_data[DATA_W-1];
                    end else begin
                        // A late last byte on this very edge already ends the frame.
                        r_underrun   <= 1'b1;
                        r_last_taken <= 1'b0;
                        r_state      <= (r_last_taken || (w_xfer && s_last)) ? S_IDLE : S_DISCARD;
                    end
                end
                S_FINISH: begin
                    r_dcnt  <= '0;
                    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_dcnt == DCW'(CRC_W - 1)) begin
                        r_state      <= S_IDLE;
                        r_last_taken <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (w_xfer && s_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_ready  = w_ready;
    assign load     = r_load;
    assign crc_in   = r_crc_in;
    assign d_finish = r_d_finish;
    assign underrun = r_underrun;
    assign busy     = (r_state != S_IDLE) && (r_state != S_DISCARD);

endmodule
